// File: rtl/hs65_complex_gate_cluster.sv
// Registered, WIDTH-lane model of the HS65 AO222, AOI13 and AOI32 complex gates.
// Define GATE_INPUT_REG_EN to add an operand register stage (latency 2 instead of 1).
module hs65_complex_gate_cluster #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ao_a1,
  input  logic [WIDTH-1:0] ao_a2,
  input  logic [WIDTH-1:0] ao_b1,
  input  logic [WIDTH-1:0] ao_b2,
  input  logic [WIDTH-1:0] ao_c1,
  input  logic [WIDTH-1:0] ao_c2,
  input  logic [WIDTH-1:0] aoi13_a,
  input  logic [WIDTH-1:0] aoi13_b,
  input  logic [WIDTH-1:0] aoi13_c,
  input  logic [WIDTH-1:0] aoi13_d,
  input  logic [WIDTH-1:0] aoi32_a1,
  input  logic [WIDTH-1:0] aoi32_a2,
  input  logic [WIDTH-1:0] aoi32_a3,
  input  logic [WIDTH-1:0] aoi32_b1,
  input  logic [WIDTH-1:0] aoi32_b2,
  output logic             out_valid,
  output logic [WIDTH-1:0] ao222_z,
  output logic [WIDTH-1:0] aoi13_z,
  output logic [WIDTH-1:0] aoi32_z
);

  // Handshake: valid-only, no ready. Operands are taken on every rising edge
  // where the valid input is high; out_valid pulses once per accepted operand
  // set and nothing can stall the pipe.

  localparam int NOPS = 15;

  logic [NOPS*WIDTH-1:0] ops_in;
  logic [NOPS*WIDTH-1:0] ev_ops;
  logic                  ev_valid;

  assign ops_in = {ao_a1, ao_a2, ao_b1, ao_b2, ao_c1, ao_c2,
                   aoi13_a, aoi13_b, aoi13_c, aoi13_d,
                   aoi32_a1, aoi32_a2, aoi32_a3, aoi32_b1, aoi32_b2};

`ifdef GATE_INPUT_REG_EN
  logic [NOPS*WIDTH-1:0] ops_q;
  logic                  in_valid_q;

  // Operand stage holds its contents on idle cycles, like the output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_q      <= '0;
      in_valid_q <= 1'b0;
    end else begin
      in_valid_q <= in_valid;
      if (in_valid) ops_q <= ops_in;
    end
  end

  assign ev_ops   = ops_q;
  assign ev_valid = in_valid_q;
`else
  assign ev_ops   = ops_in;
  assign ev_valid = in_valid;
`endif

  logic [WIDTH-1:0] e_ao_a1, e_ao_a2, e_ao_b1, e_ao_b2, e_ao_c1, e_ao_c2;
  logic [WIDTH-1:0] e_13_a, e_13_b, e_13_c, e_13_d;
  logic [WIDTH-1:0] e_32_a1, e_32_a2, e_32_a3, e_32_b1, e_32_b2;

  assign {e_ao_a1, e_ao_a2, e_ao_b1, e_ao_b2, e_ao_c1, e_ao_c2,
          e_13_a, e_13_b, e_13_c, e_13_d,
          e_32_a1, e_32_a2, e_32_a3, e_32_b1, e_32_b2} = ev_ops;

  logic             out_valid_q;
  logic [WIDTH-1:0] ao222_d, ao222_q;
  logic [WIDTH-1:0] aoi13_d_w, aoi13_q;
  logic [WIDTH-1:0] aoi32_d_w, aoi32_q;

  always_comb begin
    ao222_d   = (e_ao_a1 & e_ao_a2) | (e_ao_b1 & e_ao_b2) | (e_ao_c1 & e_ao_c2);
    aoi13_d_w = ~((e_13_a & e_13_b & e_13_c) | e_13_d);
    aoi32_d_w = ~((e_32_a1 & e_32_a2 & e_32_a3) | (e_32_b1 & e_32_b2));
  end

  // Inverting gates reset to all-ones: their value for all-zero operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ao222_q     <= '0;
      aoi13_q     <= '1;
      aoi32_q     <= '1;
    end else begin
      out_valid_q <= ev_valid;
      if (ev_valid) begin
        ao222_q <= ao222_d;
        aoi13_q <= aoi13_d_w;
        aoi32_q <= aoi32_d_w;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign ao222_z   = ao222_q;
  assign aoi13_z   = aoi13_q;
  assign aoi32_z   = aoi32_q;

endmodule

// File: tb/tb_hs65_complex_gate_cluster.sv
// Self-checking bench for hs65_complex_gate_cluster: directed gate cases,
// streaming/hold, mid-stream reset and a randomized run against a lane-level model.
module tb_hs65_complex_gate_cluster;

  localparam int W = 4;
`ifdef GATE_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid;
  logic [W-1:0] op [15];
  logic         out_valid;
  logic [W-1:0] ao222_z, aoi13_z, aoi32_z;

  hs65_complex_gate_cluster #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .ao_a1(op[0]), .ao_a2(op[1]), .ao_b1(op[2]), .ao_b2(op[3]),
    .ao_c1(op[4]), .ao_c2(op[5]),
    .aoi13_a(op[6]), .aoi13_b(op[7]), .aoi13_c(op[8]), .aoi13_d(op[9]),
    .aoi32_a1(op[10]), .aoi32_a2(op[11]), .aoi32_a3(op[12]),
    .aoi32_b1(op[13]), .aoi32_b2(op[14]),
    .out_valid(out_valid), .ao222_z(ao222_z), .aoi13_z(aoi13_z), .aoi32_z(aoi32_z)
  );

  // scoreboard: each entry is {valid, ao222, aoi13, aoi32} travelling LAT edges
  logic [3*W:0] exp_q[$];
  logic         exp_valid;
  logic [W-1:0] exp_ao, exp_13, exp_32;
  int tests_run = 0;
  int tests_failed = 0;

  // Lane-by-lane truth counting: an AND term is true when all its inputs count to its size.
  function automatic logic [3*W-1:0] ref_eval();
    logic [W-1:0] ao, n13, n32;
    for (int i = 0; i < W; i++) begin
      ao[i]  = (int'(op[0][i]) + int'(op[1][i]) == 2) ||
               (int'(op[2][i]) + int'(op[3][i]) == 2) ||
               (int'(op[4][i]) + int'(op[5][i]) == 2);
      n13[i] = !((int'(op[6][i]) + int'(op[7][i]) + int'(op[8][i]) == 3) ||
                 (int'(op[9][i]) == 1));
      n32[i] = !((int'(op[10][i]) + int'(op[11][i]) + int'(op[12][i]) == 3) ||
                 (int'(op[13][i]) + int'(op[14][i]) == 2));
    end
    return {ao, n13, n32};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int k = 1; k < LAT; k++) exp_q.push_back('0);
    exp_valid = 1'b0;
    exp_ao    = '0;
    exp_13    = '1;
    exp_32    = '1;
  endtask

  task automatic model_edge();
    logic [3*W:0] e;
    exp_q.push_back({in_valid, ref_eval()});
    e = exp_q.pop_front();
    exp_valid = e[3*W];
    if (e[3*W]) {exp_ao, exp_13, exp_32} = e[3*W-1:0];
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, W'(out_valid), W'(exp_valid));
    check({tag, ".ao222_z"}, ao222_z, exp_ao);
    check({tag, ".aoi13_z"}, aoi13_z, exp_13);
    check({tag, ".aoi32_z"}, aoi32_z, exp_32);
  endtask

  // driver: called at posedge+1; operands set by caller beforehand
  task automatic step(input logic v, input string tag);
    in_valid = v;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drain(input string tag);
    for (int k = 1; k < LAT; k++) step(1'b0, tag);
  endtask

  task automatic clear_ops();
    for (int i = 0; i < 15; i++) op[i] = '0;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 15; i++) op[i] = W'($urandom);
  endtask

  // asynchronous reset pulse kept strictly between clock edges
  task automatic mid_reset(input string tag);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    clear_ops();
    model_reset();
    #2;
    check_all("reset_init");
    check("reset_ao222_const", ao222_z, 4'b0000);
    check("reset_aoi13_const", aoi13_z, 4'b1111);
    #1 rst = 1'b0;

    // AO222 directed
    op[0] = 4'b1100; op[1] = 4'b1010; op[2] = 4'b0011; op[3] = 4'b0001;
    step(1'b1, "ao222");
    drain("ao222_drain");
    check("ao222_const", ao222_z, 4'b1001);
    check("ao222_ov", W'(out_valid), W'(1));
    step(1'b0, "ao222_idle");
    check("ao222_ov_drop", W'(out_valid), W'(0));

    // AOI13 directed
    clear_ops();
    op[6] = 4'b1111; op[7] = 4'b0101; op[8] = 4'b1111; op[9] = 4'b0011;
    step(1'b1, "aoi13_a");
    drain("aoi13_a_drain");
    check("aoi13_a_const", aoi13_z, 4'b1000);
    op[6] = 4'b1110; op[7] = 4'b1110; op[8] = 4'b1110; op[9] = 4'b0001;
    step(1'b1, "aoi13_b");
    drain("aoi13_b_drain");
    check("aoi13_b_const", aoi13_z, 4'b0000);

    // AOI32 directed
    clear_ops();
    op[10] = 4'b1111; op[11] = 4'b1100; op[12] = 4'b1010; op[13] = 4'b0110; op[14] = 4'b0011;
    step(1'b1, "aoi32");
    drain("aoi32_drain");
    check("aoi32_const", aoi32_z, 4'b0101);

    // three back-to-back vectors, then idle with random and X operands
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      step(1'b1, "stream");
    end
    drain("stream_drain");
    for (int k = 0; k < 4; k++) begin
      rand_ops();
      step(1'b0, "hold_rand");
    end
    for (int i = 0; i < 15; i++) op[i] = 'x;
    step(1'b0, "hold_x");
    step(1'b0, "hold_x2");

    // mid-stream reset and latency after release
    for (int k = 0; k < LAT; k++) begin
      rand_ops();
      step(1'b1, "pre_rst");
    end
    check("pre_rst_ov", W'(out_valid), W'(1));
    mid_reset("mid_rst");
    check("mid_rst_aoi32_const", aoi32_z, 4'b1111);
    clear_ops();
    op[0] = 4'b1100; op[1] = 4'b1010; op[2] = 4'b0011; op[3] = 4'b0001;
    step(1'b1, "post_rst");
    check("post_rst_latency", W'(out_valid), W'(LAT == 1));
    drain("post_rst_drain");
    check("post_rst_ao222_const", ao222_z, 4'b1001);
    step(1'b0, "post_rst_idle");

    // randomized run with occasional reset pulses
    for (int n = 0; n < 400; n++) begin
      rand_ops();
      step(1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 24) == 0) mid_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
